mio_bus_responder: RTL
======================

// Module: mio_bus_responder
// PURPOSE
//  Memory/IO responder that sits on the core's data port: CPU issues address/wdata/we/re, block answers with rdata + mio_ready.
//  Decodes the address into data RAM (external sync RAM port), LED/switch GPIO and a down-counter timer with interrupt.
//  Sits between the pipelined core and the board top; one access in flight at a time.
// PARAMETERS
//  RAM_AW   10  word-address bits driven to data RAM (RAM window = 4*2^RAM_AW bytes at 0x0000_0000)
//  RAM_LAT  1   data RAM read latency in cycles (>=1), ram_dout valid RAM_LAT cycles after ram_en
//  CNT_W    32  timer counter width (<=32, zero-extended on read)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  mem_addr   in   32      CPU byte address, stable while request held
//  mem_wdata  in   32      CPU write data
//  mem_we     in   1       write request
//  mem_re     in   1       read request
//  mem_rdata  out  32      read data, valid while mio_ready=1, held until next response
//  mio_ready  out  1       one-cycle completion pulse
//  mio_err    out  1       one-cycle pulse with mio_ready when address unmapped
//  ram_addr   out  RAM_AW  data RAM word address (= mem_addr[RAM_AW+1:2])
//  ram_din    out  32      data RAM write data
//  ram_en     out  1       data RAM enable
//  ram_we     out  1       data RAM write enable
//  ram_dout   in   32      data RAM read data
//  sw_in      in   16      board switches (asynchronous)
//  led_out    out  16      LED register
//  cnt_irq    out  1       timer interrupt, level
// BEHAVIOUR
//  Reset: FSM=IDLE; mem_rdata, mio_ready, mio_err, ram_en, ram_we, led_out, cnt_irq = 0; timer value/reload/ctrl = 0.
//  Map: RAM addr<4*2^RAM_AW; 0xE000_0000 R=switches{16'b0,sw}, W=led_out<=wdata[15:0];
//   0xF000_0000 R=timer value, W=load value AND reload; 0xF000_0004 ctrl: b0 en, b1 ovf (sticky), b2 irq_en.
//   ctrl write: b0/b2 written, b1 write-1-to-clear. Anything else unmapped: read 0, write ignored, mio_err=1.
//  FSM IDLE/WAIT/RESP. Request accepted only in IDLE when we|re; we has priority if both high (treated as write).
//   IDLE, RAM read: ram_en=1 (combinational, cycle T) -> WAIT for RAM_LAT cycles, capture ram_dout -> RESP.
//   IDLE, any other access: ram_en=ram_we=1 for RAM write (cycle T); IO/timer updated at edge ending T -> RESP.
//   RESP: mio_ready=1 (one cycle), requests ignored -> IDLE.
//  Latency: mio_ready at T+1, RAM read at T+1+RAM_LAT. Max throughput 1 access / 2 cycles.
//  CPU must drop we/re in the mio_ready cycle; a request still high in the following IDLE is a new access.
//  Switches: 2-flop synchronizer; read returns synchronized value (pin->readable 2 cycles).
//  Timer: if en and value!=0, value-=1 each cycle; if en and value==0: value<=reload, ovf<=1.
//   cnt_irq = ovf & irq_en. reload==0 with en: ovf set every cycle.
//   Same-cycle CPU value write and zero-reach: CPU write wins, ovf not set that cycle.
//   Same-cycle ovf set and CPU W1C clear: set wins.
//  Reset mid-access: async return to IDLE, pending response dropped, ram_en/ram_we/mio_ready low immediately.
// TESTING
//  T1 reset: rst=1 mid-RAM-read WAIT -> all outputs 0, FSM IDLE, no mio_ready after release.
//  T2 RAM_LAT=2: write 0xDEADBEEF @0x10 -> ram_we=1,ram_addr=4, ready T+1; read @0x10 -> ready T+3, rdata=0xDEADBEEF.
//  T3 GPIO: write 0x0001A5A5 @0xE000_0000 -> led_out=0xA5A5; sw_in=0x1234, wait 2 cycles, read -> 0x0000_1234.
//  T4 timer: write 3 @0xF000_0000, ctrl=0x5 -> value 3,2,1,0 then reload 3, ovf=1, cnt_irq=1; write 0x2 to ctrl -> irq=0, timer stopped.
//  T5 unmapped/priority: read @0x8000_0000 -> rdata=0, mio_err=1 with ready; we=re=1 @0xE000_0000 -> LED written, no read.
//  T6 held request: keep re high after ready -> second access accepted in next IDLE, ready pulses 2 cycles apart.

Source files
------------

// File: rtl/mio_bus_responder.sv
// mio_bus_responder
//   Memory/IO responder on the core's data port. One access is in flight at a time.
//   Decodes the CPU byte address into:
//     0x0000_0000 .. 4*2^RAM_AW-1 : data RAM (external synchronous RAM port)
//     0xE000_0000                 : R = synchronized switches, W = LED register
//     0xF000_0000                 : R = timer value, W = load value and reload
//     0xF000_0004                 : timer ctrl {irq_en, ovf, en}, ovf is write-1-to-clear
//   Any other address reads 0, ignores writes and flags mio_err with the response.
//
// Ports
//   clk, rst                 : clock (rising edge), asynchronous active-high reset
//   mem_addr/wdata/we/re     : CPU request, held until mio_ready
//   mem_rdata                : read data, held until the next read response
//   mio_ready, mio_err       : one-cycle completion pulse, unmapped-address flag
//   ram_addr/din/en/we       : data RAM request (combinational in the accept cycle)
//   ram_dout                 : data RAM read data, valid RAM_LAT cycles after ram_en
//   sw_in                    : asynchronous board switches
//   led_out                  : LED register
//   cnt_irq                  : timer interrupt level (ovf & irq_en)

module mio_bus_responder #(
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned RAM_LAT = 1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              mem_we,
    input  logic              mem_re,
    output logic [31:0]       mem_rdata,
    output logic              mio_ready,
    output logic              mio_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_en,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic              cnt_irq
);

    localparam logic [31:0] GpioAddr = 32'hE000_0000;
    localparam logic [31:0] TvalAddr = 32'hF000_0000;
    localparam logic [31:0] TctlAddr = 32'hF000_0004;
    localparam logic [7:0]  WaitInit = 8'(RAM_LAT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [7:0]       wait_q, wait_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [15:0]      sw_meta_q, sw_sync_q;
    logic [15:0]      led_q, led_d;
    logic [CNT_W-1:0] value_q, value_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             en_q, en_d;
    logic             ovf_q, ovf_d;
    logic             irq_en_q, irq_en_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic sel_ram, sel_gpio, sel_tval, sel_tctl, sel_none;

    assign sel_ram  = (mem_addr[31:RAM_AW+2] == '0);
    assign sel_gpio = (mem_addr == GpioAddr);
    assign sel_tval = (mem_addr == TvalAddr);
    assign sel_tctl = (mem_addr == TctlAddr);
    assign sel_none = !(sel_ram || sel_gpio || sel_tval || sel_tctl);

    // A request is only taken in IDLE; we wins over re.
    logic accept;
    logic wr_led, wr_tval, wr_tctl;

    assign accept  = (state_q == StIdle) && (mem_we || mem_re);
    assign wr_led  = accept && mem_we && sel_gpio;
    assign wr_tval = accept && mem_we && sel_tval;
    assign wr_tctl = accept && mem_we && sel_tctl;

    // Read data for the single-cycle (non-RAM) targets.
    logic [31:0] io_rdata;

    always_comb begin
        io_rdata = 32'h0;
        if (sel_gpio) begin
            io_rdata = {16'h0, sw_sync_q};
        end else if (sel_tval) begin
            io_rdata = 32'(value_q);
        end else if (sel_tctl) begin
            io_rdata = {29'h0, irq_en_q, ovf_q, en_q};
        end
    end

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (mem_we || mem_re) begin
                    err_d = sel_none;
                    if (mem_we) begin
                        state_d = StResp;
                    end else if (sel_ram) begin
                        state_d = StWait;
                        wait_d  = WaitInit;
                    end else begin
                        state_d = StResp;
                        rdata_d = io_rdata;
                    end
                end
            end
            StWait: begin
                if (wait_q == 8'd0) begin
                    rdata_d = ram_dout;
                    state_d = StResp;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            wait_q  <= 8'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // GPIO and timer
    // ------------------------------------------------------------------
    always_comb begin
        led_d    = led_q;
        value_d  = value_q;
        reload_d = reload_q;
        en_d     = en_q;
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;

        if (wr_led) begin
            led_d = mem_wdata[15:0];
        end

        if (en_q) begin
            if (value_q != '0) begin
                value_d = value_q - CNT_W'(1);
            end else begin
                value_d = reload_q;
            end
        end

        if (wr_tctl) begin
            en_d     = mem_wdata[0];
            irq_en_d = mem_wdata[2];
            if (mem_wdata[1]) begin
                ovf_d = 1'b0;
            end
        end

        // Applied after the W1C so a same-cycle overflow keeps ovf set; a CPU value
        // write suppresses the overflow of that cycle.
        if (wr_tval) begin
            value_d  = mem_wdata[CNT_W-1:0];
            reload_d = mem_wdata[CNT_W-1:0];
        end else if (en_q && (value_q == '0)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q <= 16'h0;
            sw_sync_q <= 16'h0;
            led_q     <= 16'h0;
            value_q   <= '0;
            reload_q  <= '0;
            en_q      <= 1'b0;
            ovf_q     <= 1'b0;
            irq_en_q  <= 1'b0;
        end else begin
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
            led_q     <= led_d;
            value_q   <= value_d;
            reload_q  <= reload_d;
            en_q      <= en_d;
            ovf_q     <= ovf_d;
            irq_en_q  <= irq_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // RAM strobes are combinational in the accept cycle; gated by rst so they drop
    // the instant reset is asserted even while a request is still held.
    assign ram_addr  = mem_addr[RAM_AW+1:2];
    assign ram_din   = mem_wdata;
    assign ram_en    = !rst && accept && sel_ram;
    assign ram_we    = !rst && accept && sel_ram && mem_we;

    assign mem_rdata = rdata_q;
    assign mio_ready = (state_q == StResp);
    assign mio_err   = (state_q == StResp) && err_q;
    assign led_out   = led_q;
    assign cnt_irq   = ovf_q && irq_en_q;

endmodule
